fifo_flex: RTL and testbench

FIFO_FLEX -- requirements
Module: fifo_flex

---
 rtl/fifo_flex_pkg.sv | 23 ++
 rtl/fifo_flex_mem.sv | 46 ++++
 rtl/fifo_flex.sv | 172 +++++++++++++++++
 tb/tb_fifo_flex.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flex_pkg.sv
// Shared constants, pointer-width helper and operation encoding for fifo_flex.
package fifo_flex_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_AE_LVL = 2;
    localparam int unsigned DEF_FWFT   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        WRRD = 2'd3
    } fifo_op_e;

    // Pointer width never drops below one bit, even for tiny depths.
    function automatic int unsigned ptr_w(input int unsigned depth);
        int unsigned w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one read port that is
// registered (FWFT=0) or combinational (FWFT=1).
module fifo_flex_mem
    import fifo_flex_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned FWFT  = DEF_FWFT,
    parameter int unsigned AW    = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    if (FWFT != 0) begin : g_fwft
        logic unused_rd;
        assign unused_rd = rd_en_i ^ rst_;
        assign rd_data_o = mem_q[rd_addr_i];
    end else begin : g_reg
        logic [WIDTH-1:0] rd_data_q;
        always_ff @(posedge clk) begin
            if (rst_) begin
                rd_data_q <= '0;
            end else if (rd_en_i) begin
                rd_data_q <= mem_q[rd_addr_i];
            end
        end
        assign rd_data_o = rd_data_q;
    end

endmodule

// File: rtl/fifo_flex.sv
// Synchronous FIFO with arbitrary depth, registered status flags and optional
// FWFT read. Define FIFO_FLEX_ERR_EN to build the sticky overflow/underflow flags.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned AF_LVL = DEPTH - 2,
    parameter int unsigned AE_LVL = DEF_AE_LVL,
    parameter int unsigned FWFT   = DEF_FWFT
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic                       fifo_write,
    input  logic [WIDTH-1:0]           fifo_data_in,
    input  logic                       fifo_read,
    output logic [WIDTH-1:0]           fifo_data_out,
    output logic                       fifo_rd_valid,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       fifo_afull,
    output logic                       fifo_aempty,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt,
    input  logic                       fifo_err_clr,
    output logic                       fifo_ovf,
    output logic                       fifo_udf
);

    localparam int unsigned AW = ptr_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          wr_acc, rd_acc;
    fifo_op_e      op;

    // Acceptance uses the registered flags, so full+wr+rd is read-only and
    // empty+wr+rd is write-only with no bypass.
    always_comb begin
        wr_acc   = fifo_write && !full_q;
        rd_acc   = fifo_read && !empty_q;
        op       = IDLE;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_acc && rd_acc) begin
            op = WRRD;
        end else if (wr_acc) begin
            op = WR;
        end else if (rd_acc) begin
            op = RD;
        end
        if (op == WR || op == WRRD) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (op == RD || op == WRRD) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end
        case (op)
            WR:      cnt_d = cnt_q + CW'(1);
            RD:      cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        full_d   = (cnt_d == CNT_MAX);
        empty_d  = (cnt_d == '0);
        afull_d  = (32'(cnt_d) >= AF_LVL);
        aempty_d = (32'(cnt_d) <= AE_LVL);
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
        end
    end

    fifo_flex_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .FWFT  (FWFT),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .rst_      (rst_),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (fifo_data_in),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (fifo_data_out)
    );

    if (FWFT != 0) begin : g_vld_fwft
        assign fifo_rd_valid = !empty_q;
    end else begin : g_vld_reg
        logic rd_valid_q;
        always_ff @(posedge clk) begin
            if (rst_) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
            end
        end
        assign fifo_rd_valid = rd_valid_q;
    end

    assign fifo_full   = full_q;
    assign fifo_empty  = empty_q;
    assign fifo_afull  = afull_q;
    assign fifo_aempty = aempty_q;
    assign fifo_cnt    = cnt_q;

`ifdef FIFO_FLEX_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // A set event in the same cycle as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (fifo_err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (fifo_write && full_q && !fifo_read) begin
            ovf_d = 1'b1;
        end
        if (fifo_read && empty_q && !fifo_write) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign fifo_ovf = ovf_q;
    assign fifo_udf = udf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = fifo_err_clr;
    assign fifo_ovf = 1'b0;
    assign fifo_udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a DEPTH=16 and a DEPTH=5 instance share stimulus and are
// compared every cycle against queue-based reference models.
module tb_fifo_flex;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr;
    logic        rd;
    logic        clr;
    logic [15:0] din;

    logic [15:0] dout16, dout5;
    logic        vld16, vld5, full16, full5, empty16, empty5;
    logic        afull16, afull5, aempty16, aempty5;
    logic        ovf16, ovf5, udf16, udf5;
    logic [4:0]  cnt16;
    logic [2:0]  cnt5;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned m_depth [2] = '{16, 5};
    logic [15:0] mq [2][$];
    int unsigned m_wp [2];
    int unsigned m_rp [2];
    logic [15:0] m_dout [2];
    logic        m_vld [2];
    logic        m_ovf [2];
    logic        m_udf [2];

    always #5 clk = ~clk;

    fifo_flex #(.WIDTH(16), .DEPTH(16)) dut16 (
        .clk(clk), .rst_(rst), .fifo_write(wr), .fifo_data_in(din), .fifo_read(rd),
        .fifo_data_out(dout16), .fifo_rd_valid(vld16), .fifo_full(full16),
        .fifo_empty(empty16), .fifo_afull(afull16), .fifo_aempty(aempty16),
        .fifo_cnt(cnt16), .fifo_err_clr(clr), .fifo_ovf(ovf16), .fifo_udf(udf16)
    );

    fifo_flex #(.WIDTH(16), .DEPTH(5)) dut5 (
        .clk(clk), .rst_(rst), .fifo_write(wr), .fifo_data_in(din), .fifo_read(rd),
        .fifo_data_out(dout5), .fifo_rd_valid(vld5), .fifo_full(full5),
        .fifo_empty(empty5), .fifo_afull(afull5), .fifo_aempty(aempty5),
        .fifo_cnt(cnt5), .fifo_err_clr(clr), .fifo_ovf(ovf5), .fifo_udf(udf5)
    );

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    // Reference behaviour: occupancy is the queue length, pointers count accepted ops mod depth.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit full_m, empty_m, wa, ra;
            full_m  = (mq[i].size() == m_depth[i]);
            empty_m = (mq[i].size() == 0);
            wa = wr && !full_m;
            ra = rd && !empty_m;
            if (rst) begin
                mq[i].delete();
                m_wp[i] = 0; m_rp[i] = 0;
                m_dout[i] = '0; m_vld[i] = 1'b0;
                m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
            end else begin
`ifdef FIFO_FLEX_ERR_EN
                if (clr) begin m_ovf[i] = 1'b0; m_udf[i] = 1'b0; end
                if (wr && full_m && !rd)  m_ovf[i] = 1'b1;
                if (rd && empty_m && !wr) m_udf[i] = 1'b1;
`endif
                m_vld[i] = ra;
                if (ra) begin
                    m_dout[i] = mq[i].pop_front();
                    m_rp[i] = (m_rp[i] + 1) % m_depth[i];
                end
                if (wa) begin
                    mq[i].push_back(din);
                    m_wp[i] = (m_wp[i] + 1) % m_depth[i];
                end
            end
        end
    endtask

    task automatic chk_inst(input int i, input int unsigned cnt, input int unsigned full,
                            input int unsigned empty, input int unsigned afull,
                            input int unsigned aempty, input int unsigned vld,
                            input int unsigned dout, input int unsigned ovf,
                            input int unsigned udf, input int unsigned wp, input int unsigned rp);
        int unsigned sz;
        string p;
        sz = mq[i].size();
        p = $sformatf("d%0d_", m_depth[i]);
        chk({p, "cnt"},    cnt,    sz);
        chk({p, "full"},   full,   (sz == m_depth[i]) ? 1 : 0);
        chk({p, "empty"},  empty,  (sz == 0) ? 1 : 0);
        chk({p, "afull"},  afull,  (sz >= m_depth[i] - 2) ? 1 : 0);
        chk({p, "aempty"}, aempty, (sz <= 2) ? 1 : 0);
        chk({p, "rd_vld"}, vld,    32'(m_vld[i]));
        chk({p, "dout"},   dout,   32'(m_dout[i]));
        chk({p, "ovf"},    ovf,    32'(m_ovf[i]));
        chk({p, "udf"},    udf,    32'(m_udf[i]));
        chk({p, "wr_ptr"}, wp,     m_wp[i]);
        chk({p, "rd_ptr"}, rp,     m_rp[i]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk_inst(0, 32'(cnt16), 32'(full16), 32'(empty16), 32'(afull16), 32'(aempty16),
                 32'(vld16), 32'(dout16), 32'(ovf16), 32'(udf16),
                 32'(dut16.wr_ptr_q), 32'(dut16.rd_ptr_q));
        chk_inst(1, 32'(cnt5), 32'(full5), 32'(empty5), 32'(afull5), 32'(aempty5),
                 32'(vld5), 32'(dout5), 32'(ovf5), 32'(udf5),
                 32'(dut5.wr_ptr_q), 32'(dut5.rd_ptr_q));
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned wp_before;
        int unsigned p_wr, p_rd;
        logic [15:0] sent;

        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr = 1'b0; din = '0;
        for (int i = 0; i < 2; i++) begin
            m_wp[i] = 0; m_rp[i] = 0; m_dout[i] = '0;
            m_vld[i] = 1'b0; m_ovf[i] = 1'b0; m_udf[i] = 1'b0;
        end

        // Reset then idle
        cycle();
        rst = 1'b0;
        cycle();
        chk("reset_cnt", 32'(cnt16), 0);
        chk("reset_empty", 32'(empty16), 1);
        chk("reset_aempty", 32'(aempty16), 1);
        chk("reset_full", 32'(full16), 0);
        chk("reset_rd_valid", 32'(vld16), 0);

        // Fill with 0x0000..0x000F, then one write too many
        for (int k = 0; k < 16; k++) begin
            wr = 1'b1; din = 16'(k);
            cycle();
            if (k == 12) chk("fill_afull_at13", 32'(afull16), 0);
            if (k == 13) chk("fill_afull_at14", 32'(afull16), 1);
        end
        chk("fill_full", 32'(full16), 1);
        chk("fill_cnt", 32'(cnt16), 16);
        din = 16'h0010;
        cycle();
        chk("fill_cnt_after17", 32'(cnt16), 16);
`ifdef FIFO_FLEX_ERR_EN
        chk("fill_ovf", 32'(ovf16), 1);
`else
        chk("fill_ovf_tied", 32'(ovf16), 0);
`endif

        // Full with write+read: read only
        wp_before = 32'(dut16.wr_ptr_q);
        wr = 1'b1; rd = 1'b1; din = 16'h1234;
        cycle();
        chk("fullwr_cnt", 32'(cnt16), 15);
        chk("fullwr_wptr", 32'(dut16.wr_ptr_q), wp_before);
        chk("fullwr_dout", 32'(dout16), 32'h0000);
        wr = 1'b0; rd = 1'b0;
        cycle();

        // Empty with write+read: write only
        do_reset();
        cycle();
        wr = 1'b1; rd = 1'b1; din = 16'hA5A5;
        cycle();
        chk("emptywr_cnt", 32'(cnt16), 1);
        chk("emptywr_rptr", 32'(dut16.rd_ptr_q), 0);
        chk("emptywr_rd_valid", 32'(vld16), 0);
        chk("emptywr_udf", 32'(udf16), 0);
        wr = 1'b0; rd = 1'b1;
        cycle();
        chk("emptywr_dout", 32'(dout16), 32'hA5A5);
        rd = 1'b0;

        // Alternating write/read pairs, wraps the DEPTH=5 pointers twice
        do_reset();
        for (int k = 0; k < 12; k++) begin
            sent = 16'($urandom);
            wr = 1'b1; rd = 1'b0; din = sent;
            cycle();
            chk("alt_cnt5_le1", (cnt5 <= 3'd1) ? 1 : 0, 1);
            wr = 1'b0; rd = 1'b1;
            cycle();
            chk("alt_dout5", 32'(dout5), 32'(sent));
            chk("alt_vld5", 32'(vld5), 1);
        end
        rd = 1'b0;
        chk("alt_wptr5", 32'(dut5.wr_ptr_q), 2);

        // Reset during a read at cnt=7
        do_reset();
        for (int k = 0; k < 7; k++) begin
            wr = 1'b1; din = 16'(16'h0100 + k);
            cycle();
        end
        wr = 1'b0;
        chk("rstrd_cnt_before", 32'(cnt16), 7);
        rst = 1'b1; rd = 1'b1;
        cycle();
        chk("rstrd_cnt", 32'(cnt16), 0);
        chk("rstrd_empty", 32'(empty16), 1);
        chk("rstrd_vld", 32'(vld16), 0);
        rst = 1'b0;
        cycle();
        chk("rstrd_rej_cnt", 32'(cnt16), 0);
        chk("rstrd_rej_vld", 32'(vld16), 0);
        rd = 1'b0;

        // Randomized traffic with drifting fill bias, error clears and rare resets
        p_wr = 50; p_rd = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                p_wr = $urandom_range(15, 85);
                p_rd = $urandom_range(15, 85);
            end
            rst = ($urandom_range(0, 299) == 0);
            wr  = ($urandom_range(0, 99) < p_wr);
            rd  = ($urandom_range(0, 99) < p_rd);
            clr = ($urandom_range(0, 15) == 0);
            din = 16'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
